// File: rtl/mem_dma_if.sv
// Bundles the copy-engine request, status and memory-bus signals.
// master: requester plus memory side (drives start/config and mem_rdata); slave: the DMA engine.
interface mem_dma_if #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int LW = AW + 1
);
  logic          start;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [LW-1:0] len;
  logic          fill;
  logic [DW-1:0] fill_val;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write;
  logic [DW-1:0] mem_rdata;

  modport master (
    output start, src, dst, len, fill, fill_val, mem_rdata,
    input  busy, done, mem_addr, mem_wdata, mem_write
  );

  modport slave (
    input  start, src, dst, len, fill, fill_val, mem_rdata,
    output busy, done, mem_addr, mem_wdata, mem_write
  );
endinterface

// File: rtl/mem_dma.sv
// Single-channel byte copy engine driving a single-port memory (READ cycle then WRITE cycle per byte).
// Optional fill mode (write fill_val, no reads) is compiled in when MEM_DMA_FILL_EN is defined.
module mem_dma #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int LW = AW + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_dma_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d;
  logic [LW-1:0] len_q, len_d, idx_q, idx_d, idx_inc;
  logic [DW-1:0] data_q, data_d;
  logic          fill_q, fill_d;
  logic [DW-1:0] fill_val_q, fill_val_d;
  logic          fill_start;
  logic [DW-1:0] fill_val_in;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write;

`ifdef MEM_DMA_FILL_EN
  assign fill_start  = bus.fill;
  assign fill_val_in = bus.fill_val;
`else
  // Fill ports stay on the interface in every build but carry no meaning here.
  logic unused_fill;
  assign fill_start  = 1'b0;
  assign fill_val_in = '0;
  assign unused_fill = ^{bus.fill, bus.fill_val};
`endif

  assign idx_inc = idx_q + LW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      fill_q     <= 1'b0;
      fill_val_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      fill_q     <= fill_d;
      fill_val_q <= fill_val_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    idx_d      = idx_q;
    data_d     = data_q;
    fill_d     = fill_q;
    fill_val_d = fill_val_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          src_d      = bus.src;
          dst_d      = bus.dst;
          len_d      = bus.len;
          idx_d      = '0;
          fill_d     = fill_start;
          fill_val_d = fill_val_in;
          if (bus.len == '0)   state_d = DONE;
          else if (fill_start) state_d = WRITE;
          else                 state_d = READ;
        end
      end
      READ: begin
        data_d  = bus.mem_rdata;
        state_d = WRITE;
      end
      WRITE: begin
        idx_d = idx_inc;
        // Compare at full LW width so a 2**AW-byte transfer terminates.
        if (idx_inc == len_q) state_d = DONE;
        else if (fill_q)      state_d = WRITE;
        else                  state_d = READ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs decode purely from registered state; addresses wrap mod 2**AW.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    case (state_q)
      READ:  mem_addr = src_q + idx_q[AW-1:0];
      WRITE: begin
        mem_addr  = dst_q + idx_q[AW-1:0];
        mem_wdata = fill_q ? fill_val_q : data_q;
        mem_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_write = mem_write;

endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma with a behavioural 256x8 memory (combinational read).
// Expectations for the fill test follow MEM_DMA_FILL_EN as the RTL is built.
module tb_mem_dma;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_dma_if #(.AW(8), .DW(8), .LW(9)) bus ();

  mem_dma #(.AW(8), .DW(8), .LW(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [256];
  logic       poke_we = 1'b0;
  logic [7:0] poke_a = '0;
  logic [7:0] poke_d = '0;
  int         wr_total = 0;

  // Bench preload port and DMA writes share one process; preloads only happen while idle.
  always @(posedge clk) begin
    if (poke_we) mem[poke_a] <= poke_d;
    else if (bus.mem_write) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr_total <= wr_total + 1;
    end
  end

  assign bus.mem_rdata = mem[bus.mem_addr];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    poke_a  = a;
    poke_d  = d;
    poke_we = 1'b1;
    @(negedge clk);
    poke_we = 1'b0;
  endtask

  // Called on a negedge; returns on the first negedge after the accept edge (cycle n=1).
  task automatic issue(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l,
                       input logic f, input logic [7:0] fv);
    bus.src      = s;
    bus.dst      = d;
    bus.len      = l;
    bus.fill     = f;
    bus.fill_val = fv;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit, output int busy_cnt, output int done_at);
    busy_cnt = 0;
    done_at  = 0;
    for (int n = 1; n <= limit; n++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_at = n;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_idle_done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bc;
    int da;
    int w0;
    bus.start    = 1'b0;
    bus.src      = '0;
    bus.dst      = '0;
    bus.len      = '0;
    bus.fill     = 1'b0;
    bus.fill_val = '0;

    #1;
    check("rst_busy",  32'(bus.busy),      32'd0);
    check("rst_done",  32'(bus.done),      32'd0);
    check("rst_write", 32'(bus.mem_write), 32'd0);
    check("rst_addr",  32'(bus.mem_addr),  32'd0);
    check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    poke(8'h10, 8'hA0); poke(8'h11, 8'hA1); poke(8'h12, 8'hA2);
    poke(8'h13, 8'hA3); poke(8'h14, 8'hA4);
    poke(8'hFE, 8'h11); poke(8'hFF, 8'h22); poke(8'h00, 8'h33);
    poke(8'h30, 8'h61); poke(8'h31, 8'h62); poke(8'h32, 8'h63); poke(8'h33, 8'h64);
    poke(8'h50, 8'hEE); poke(8'h51, 8'hEE); poke(8'h52, 8'hEE); poke(8'h53, 8'hEE);
    poke(8'hC0, 8'hEE); poke(8'hC1, 8'hEE);

    // Basic 4-byte copy
    w0 = wr_total;
    issue(8'h10, 8'h80, 9'd4, 1'b0, 8'h00);
    wait_done("t1", 40, bc, da);
    check("t1_done_at", 32'(da), 32'd9);
    check("t1_busy_cycles", 32'(bc), 32'd9);
    check("t1_writes", 32'(wr_total - w0), 32'd4);
    check("t1_m80", 32'(mem[8'h80]), 32'hA0);
    check("t1_m81", 32'(mem[8'h81]), 32'hA1);
    check("t1_m82", 32'(mem[8'h82]), 32'hA2);
    check("t1_m83", 32'(mem[8'h83]), 32'hA3);

    // Zero length
    w0 = wr_total;
    issue(8'h05, 8'h06, 9'd0, 1'b0, 8'h00);
    wait_done("t2", 10, bc, da);
    check("t2_done_at", 32'(da), 32'd1);
    check("t2_busy_cycles", 32'(bc), 32'd1);
    check("t2_writes", 32'(wr_total - w0), 32'd0);

    // Reset during WRITE of byte 2
    issue(8'h30, 8'h50, 9'd4, 1'b0, 8'h00);
    repeat (5) @(negedge clk);
    check("t5_write_b2", 32'(bus.mem_write), 32'd1);
    check("t5_addr_b2", 32'(bus.mem_addr), 32'h52);
    rst_n = 1'b0;
    #1;
    check("t5_rst_write", 32'(bus.mem_write), 32'd0);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_done", 32'(bus.done), 32'd0);
    check("t5_rst_addr", 32'(bus.mem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_m50", 32'(mem[8'h50]), 32'h61);
    check("t5_m51", 32'(mem[8'h51]), 32'h62);
    check("t5_m52", 32'(mem[8'h52]), 32'hEE);
    check("t5_m53", 32'(mem[8'h53]), 32'hEE);

    // Source wraps past 0xFF; also the first transfer after the abort
    issue(8'hFE, 8'h40, 9'd3, 1'b0, 8'h00);
    wait_done("t3", 30, bc, da);
    check("t3_done_at", 32'(da), 32'd7);
    check("t3_m40", 32'(mem[8'h40]), 32'h11);
    check("t3_m41", 32'(mem[8'h41]), 32'h22);
    check("t3_m42", 32'(mem[8'h42]), 32'h33);

    // Start re-asserted mid-copy must be ignored
    w0 = wr_total;
    issue(8'h10, 8'h88, 9'd4, 1'b0, 8'h00);
    @(negedge clk);
    bus.src   = 8'h00;
    bus.dst   = 8'hC0;
    bus.len   = 9'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("t4", 40, bc, da);
    check("t4_done_at", 32'(da), 32'd7);
    check("t4_writes", 32'(wr_total - w0), 32'd4);
    check("t4_m88", 32'(mem[8'h88]), 32'hA0);
    check("t4_m8b", 32'(mem[8'h8B]), 32'hA3);
    check("t4_mc0", 32'(mem[8'hC0]), 32'hEE);
    check("t4_mc1", 32'(mem[8'hC1]), 32'hEE);

    // Fill request: fill in the macro build, plain copy otherwise
    w0 = wr_total;
    issue(8'h10, 8'h20, 9'd5, 1'b1, 8'h5A);
    wait_done("t6", 40, bc, da);
    check("t6_writes", 32'(wr_total - w0), 32'd5);
`ifdef MEM_DMA_FILL_EN
    check("t6_done_at", 32'(da), 32'd6);
    check("t6_m20", 32'(mem[8'h20]), 32'h5A);
    check("t6_m22", 32'(mem[8'h22]), 32'h5A);
    check("t6_m24", 32'(mem[8'h24]), 32'h5A);
`else
    check("t6_done_at", 32'(da), 32'd11);
    check("t6_m20", 32'(mem[8'h20]), 32'hA0);
    check("t6_m22", 32'(mem[8'h22]), 32'hA2);
    check("t6_m24", 32'(mem[8'h24]), 32'hA4);
`endif

    // Whole memory onto itself (len = 256)
    w0 = wr_total;
    issue(8'h00, 8'h00, 9'd256, 1'b0, 8'h00);
    wait_done("t7", 600, bc, da);
    check("t7_done_at", 32'(da), 32'd513);
    check("t7_busy_cycles", 32'(bc), 32'd513);
    check("t7_writes", 32'(wr_total - w0), 32'd256);
    check("t7_m10", 32'(mem[8'h10]), 32'hA0);
    check("t7_m41", 32'(mem[8'h41]), 32'h22);
    check("t7_mff", 32'(mem[8'hFF]), 32'h22);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
